// File: rtl/dcache_wt.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// Loads hit one cycle after the request is presented; misses and all stores use a single-outstanding memory port.
module dcache_wt #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        re,
  input  logic [31:0] raddr,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [2:0]  access_sz,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef struct packed {
    logic        vld;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sz;
  } req_t;

  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;

  state_t             state, state_n;
  req_t               rq, rq_n;
  logic [31:0]        data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]   valid;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            ofs;
  logic                  line_hit, fill, st_upd;
  logic [3:0]            strb;
  logic [31:0]           wdata_sh;

  assign idx      = rq.addr[INDEX_BITS+1:2];
  assign tag      = rq.addr[31:INDEX_BITS+2];
  assign ofs      = rq.addr[1:0];
  assign line_hit = valid[idx] && (tag_mem[idx] == tag);

  assign rq_n = '{vld: re | we, we: we, addr: we ? waddr : raddr, wdata: wdata, sz: access_sz};

  // Lane steering; a misaligned half simply loses the strobe bits shifted past lane 3.
  always_comb begin
    case (rq.sz)
      3'd0: begin
        strb     = 4'b0001 << ofs;
        wdata_sh = {24'b0, rq.wdata[7:0]} << {ofs, 3'b000};
      end
      3'd1: begin
        strb     = 4'b0011 << ofs;
        wdata_sh = {16'b0, rq.wdata[15:0]} << {ofs, 3'b000};
      end
      default: begin
        strb     = 4'b1111;
        wdata_sh = rq.wdata;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    hit     = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    fill    = 1'b0;
    st_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (rq.vld) begin
          if (rq.we) begin
            st_upd  = line_hit;
            state_n = WRITE;
          end else if (line_hit) begin
            hit = 1'b1;
          end else begin
            state_n = MISS;
          end
        end
      end
      MISS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          hit     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // mem_* derive from the held request, so they cannot move while mem_req is up.
  assign mem_addr  = mem_req ? {rq.addr[31:2], 2'b00} : 32'b0;
  assign mem_wdata = mem_we ? wdata_sh : 32'b0;
  assign mem_wstrb = mem_we ? strb : 4'b0;
  assign rdata     = (state == IDLE && hit) ? data_mem[idx] : 32'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rq    <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE || hit) rq <= rq_n;
      if (fill) valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[idx] <= mem_rdata;
      tag_mem[idx]  <= tag;
    end else if (st_upd) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) data_mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end
endmodule
